core_seq: RTL and testbench
===========================

Name: core_seq

Overview:
- Parametrised multi-cycle instruction sequencer for the nano_riscv core. It replaces the fixed IF/ID/EX/MEM/WB stepping with a sequencer that has:
  - memory wait-state stall on `busy`;
  - instruction-boundary debug halt with halted acknowledge;
  - a synchronous core reset request;
  - a bus-timeout watchdog;
  - a retired-instruction counter.
- Owns the PC register. Sits between control/ex (decode and branch info) and the shared memory port.

Parameters:
- XLEN, 32, width of PC and jump address.
- PC_RESET, 32'h0000_0000, PC value after reset or reset request.
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 255, consecutive busy cycles in IF/MEM that trip the watchdog; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous active-low reset.
- busy  in  1  memory not ready; the current IF/MEM access must be held.
- is_mem  in  1  decoded instruction is a load or store; sampled in EX.
- jump  in  1  taken branch/jump; sampled in WB.
- jump_addr  in  XLEN  branch/jump target; sampled in WB.
- halt_req_i  in  1  debug halt request (level).
- reset_req_i  in  1  debug core reset request (level).
- state  out  5  one-hot state: bit0 IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB; all zero in HALT.
- pc  out  XLEN  current instruction address.
- mem_req  out  1  high in IF and MEM states only.
- halted_o  out  1  high while in HALT.
- timeout_o  out  1  sticky watchdog error flag.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (rstn low at clk edge):
  - state = 5'b00001 (IF), pc = PC_RESET, retired = 0.
  - halted_o = 0, timeout_o = 0, wait counter = 0.
- reset_req_i high at clk edge: same as reset, except retired holds its value. Highest priority over every other event, including during HALT or a stalled access.
- Priority at any edge: rstn, then reset_req_i, then watchdog trip, then normal transition.
- IF:
  - busy = 1: stay in IF, wait counter +1.
  - busy = 0: go to ID, wait counter cleared.
- ID: always go to EX after 1 cycle.
- EX:
  - is_mem = 1: go to MEM.
  - is_mem = 0: go to WB.
- MEM: same busy/wait rule as IF; on busy = 0 go to WB.
- WB (1 cycle):
  - pc <= jump ? {jump_addr[XLEN-1:2], 2'b00} : pc + 4. Modulo 2^XLEN, so it wraps from all-ones to 0.
  - retired <= retired + 1, wrapping at 2^CNT_W.
  - Next state: HALT if halt_req_i = 1, else IF.
- Instruction latency with no stalls: 4 cycles for non-memory instructions, 5 cycles for memory instructions; add one cycle per busy cycle.
- halt_req_i is sampled only in WB and in HALT. A request raised mid-instruction lets that instruction complete. A request that drops before WB is ignored.
- HALT:
  - state = 0, mem_req = 0, halted_o = 1; pc and retired hold.
  - Exit to IF on the first edge where halt_req_i = 0 and timeout_o = 0.
- Watchdog (MEM_TIMEOUT > 0):
  - Trips when the wait counter equals MEM_TIMEOUT - 1 and busy = 1 in IF or MEM, i.e. on the MEM_TIMEOUT-th consecutive busy cycle.
  - On trip: timeout_o <= 1, state <= HALT, pc unchanged, retired unchanged, no WB.
  - timeout_o is cleared only by rstn or reset_req_i, so the core stays in HALT until then.
  - Wait counter width is clog2(MEM_TIMEOUT+1); it saturates and never wraps.
- MEM_TIMEOUT = 0: the wait counter is unused, timeout_o stays 0, and busy can stall indefinitely.
- busy is ignored outside IF/MEM.
- All outputs are registered, or decoded combinationally from registered state only. No combinational path from any input to any output.

Test Plan:
- Reset then busy = 0, is_mem = 0, jump = 0 for 12 cycles:
  - state sequence IF, ID, EX, WB repeats.
  - pc = 0, 4, 8 at successive IF entries.
  - retired = 3 after the third WB.
- is_mem = 1 with busy high for 3 cycles in MEM:
  - MEM held 4 cycles, instruction takes 8 cycles total.
  - mem_req high throughout MEM.
- jump = 1 in WB with jump_addr = 32'h0000_1003: next IF shows pc = 32'h0000_1000. Separately, pc = 32'hFFFF_FFFC with no jump: next pc = 0.
- halt_req_i raised during EX:
  - WB completes and retired increments.
  - Then HALT: state = 0, halted_o = 1, mem_req = 0.
  - Drop halt_req_i: IF on the next edge with the updated pc.
- MEM_TIMEOUT = 4, busy held high in IF:
  - On the 4th busy cycle timeout_o = 1 and state goes to HALT; pc unchanged.
  - Drop busy and halt_req_i: core stays halted.
  - Pulse reset_req_i: back to IF, pc = PC_RESET, retired preserved, timeout_o = 0.
- reset_req_i asserted in the same cycle as a WB with jump = 1: pc = PC_RESET, retired not incremented, state = IF.

Source files
------------

// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer for the nano_riscv core.
// Steps each instruction through IF -> ID -> EX -> (MEM) -> WB, owns the PC,
// stalls IF/MEM accesses on busy, halts at instruction boundaries for debug,
// honours a synchronous core reset request, trips a bus-timeout watchdog and
// counts retired instructions.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rstn         synchronous active-low reset
//   busy         memory not ready, hold the current IF/MEM access
//   is_mem       decoded instruction is a load/store (sampled in EX)
//   jump         taken branch/jump (sampled in WB)
//   jump_addr    branch/jump target (sampled in WB)
//   halt_req_i   debug halt request (level)
//   reset_req_i  debug core reset request (level)
//   state        one-hot state {WB,MEM,EX,ID,IF}, all zero in HALT
//   pc           current instruction address
//   mem_req      memory request, high in IF and MEM
//   halted_o     high while halted
//   timeout_o    sticky watchdog error flag
//   retired      retired-instruction counter
module core_seq #(
  parameter int unsigned          XLEN        = 32,
  parameter logic [XLEN-1:0]      PC_RESET    = 32'h0000_0000,
  parameter int unsigned          CNT_W       = 32,
  parameter int unsigned          MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             busy,
  input  logic             is_mem,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_addr,
  input  logic             halt_req_i,
  input  logic             reset_req_i,
  output logic [4:0]       state,
  output logic [XLEN-1:0]  pc,
  output logic             mem_req,
  output logic             halted_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] retired
);

  // Counter must hold 0..MEM_TIMEOUT; keep at least one bit when disabled.
  localparam int unsigned WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] TRIP_VAL = (MEM_TIMEOUT > 0) ? WW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [4:0] {
    S_HALT = 5'b00000,
    S_IF   = 5'b00001,
    S_ID   = 5'b00010,
    S_EX   = 5'b00100,
    S_MEM  = 5'b01000,
    S_WB   = 5'b10000
  } state_t;

  state_t           state_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] retired_q;
  logic             timeout_q;
  logic [WW-1:0]    wait_q;
  logic             in_access;
  logic             trip;

  // Next PC after writeback: word-aligned jump target or sequential +4.
  function automatic logic [XLEN-1:0] next_pc(input logic             j,
                                               input logic [XLEN-1:0] tgt,
                                               input logic [XLEN-1:0] cur);
    logic [XLEN-1:0] r;
    if (j) r = {tgt[XLEN-1:2], 2'b00};
    else   r = cur + XLEN'(4);
    return r;
  endfunction

  assign in_access = (state_q == S_IF) || (state_q == S_MEM);
  // Trips on the MEM_TIMEOUT-th consecutive busy cycle of one access.
  assign trip = (MEM_TIMEOUT > 0) && in_access && busy && (wait_q == TRIP_VAL);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IF;
      pc_q      <= PC_RESET;
      retired_q <= '0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
    end else if (reset_req_i) begin
      // Core reset request: like rstn but the retired count survives.
      state_q   <= S_IF;
      pc_q      <= PC_RESET;
      timeout_q <= 1'b0;
      wait_q    <= '0;
    end else if (trip) begin
      timeout_q <= 1'b1;
      state_q   <= S_HALT;
      wait_q    <= '0;
    end else begin
      case (state_q)
        S_IF, S_MEM: begin
          if (busy) begin
            if ((MEM_TIMEOUT > 0) && (wait_q != WAIT_MAX)) wait_q <= wait_q + WW'(1);
          end else begin
            wait_q  <= '0;
            state_q <= (state_q == S_IF) ? S_ID : S_WB;
          end
        end
        S_ID: state_q <= S_EX;
        S_EX: state_q <= is_mem ? S_MEM : S_WB;
        S_WB: begin
          pc_q      <= next_pc(jump, jump_addr, pc_q);
          retired_q <= retired_q + CNT_W'(1);
          state_q   <= halt_req_i ? S_HALT : S_IF;
        end
        S_HALT: begin
          // A watchdog trip keeps the core parked until a reset.
          if (!halt_req_i && !timeout_q) state_q <= S_IF;
        end
        default: state_q <= S_IF;
      endcase
    end
  end

  assign state     = state_q;
  assign pc        = pc_q;
  assign mem_req   = in_access;
  assign halted_o  = (state_q == S_HALT);
  assign timeout_o = timeout_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;

  localparam logic [4:0] HL = 5'b00000;
  localparam logic [4:0] IF = 5'b00001;
  localparam logic [4:0] ID = 5'b00010;
  localparam logic [4:0] EX = 5'b00100;
  localparam logic [4:0] ME = 5'b01000;
  localparam logic [4:0] WB = 5'b10000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        busy;
  logic        is_mem;
  logic        jump;
  logic [31:0] jump_addr;
  logic        halt_req_i;
  logic        reset_req_i;
  logic [4:0]  state;
  logic [31:0] pc;
  logic        mem_req;
  logic        halted_o;
  logic        timeout_o;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        b;
    logic        m;
    logic        j;
    logic [31:0] ja;
    logic        h;
    logic [4:0]  es;
    logic [31:0] epc;
    logic [31:0] er;
  } vec_t;

  vec_t vq[$];

  core_seq #(
    .XLEN(32), .PC_RESET(32'h0000_0000), .CNT_W(32), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rstn(rstn), .busy(busy), .is_mem(is_mem), .jump(jump),
    .jump_addr(jump_addr), .halt_req_i(halt_req_i), .reset_req_i(reset_req_i),
    .state(state), .pc(pc), .mem_req(mem_req), .halted_o(halted_o),
    .timeout_o(timeout_o), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] es, input logic [31:0] epc,
                           input logic [31:0] er, input logic eto);
    chk({tag, ".state"},   {27'd0, state}, {27'd0, es});
    chk({tag, ".pc"},      pc, epc);
    chk({tag, ".retired"}, retired, er);
    chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, (es == IF) || (es == ME)});
    chk({tag, ".halted"},  {31'd0, halted_o}, {31'd0, es == HL});
    chk({tag, ".timeout"}, {31'd0, timeout_o}, {31'd0, eto});
  endtask

  task automatic drive(input logic b, input logic m, input logic j, input logic [31:0] ja,
                       input logic h, input logic rr);
    busy = b; is_mem = m; jump = j; jump_addr = ja; halt_req_i = h; reset_req_i = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic b, input logic m, input logic j, input logic [31:0] ja,
                     input logic h, input logic [4:0] es, input logic [31:0] epc,
                     input logic [31:0] er);
    vec_t v;
    v.b = b; v.m = m; v.j = j; v.ja = ja; v.h = h; v.es = es; v.epc = epc; v.er = er;
    vq.push_back(v);
  endtask

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check_all("reset", IF, 32'h0, 32'd0, 1'b0);
    rstn = 1'b1;

    // Three plain instructions: IF ID EX WB repeating, pc 0,4,8 -> 12.
    for (int k = 0; k < 3; k++) begin
      add(0, 0, 0, 0, 0, ID, 32'(4 * k), 32'(k));
      add(0, 0, 0, 0, 0, EX, 32'(4 * k), 32'(k));
      add(0, 0, 0, 0, 0, WB, 32'(4 * k), 32'(k));
      add(0, 0, 0, 0, 0, IF, 32'(4 * k + 4), 32'(k + 1));
    end
    // Memory instruction, busy 3 cycles in MEM, busy ignored in ID; jump to 0x1003.
    add(0, 0, 0, 0, 0, ID, 32'd12, 32'd3);
    add(1, 0, 0, 0, 0, EX, 32'd12, 32'd3);
    add(0, 1, 0, 0, 0, ME, 32'd12, 32'd3);
    add(1, 0, 0, 0, 0, ME, 32'd12, 32'd3);
    add(1, 0, 0, 0, 0, ME, 32'd12, 32'd3);
    add(1, 0, 0, 0, 0, ME, 32'd12, 32'd3);
    add(0, 0, 0, 0, 0, WB, 32'd12, 32'd3);
    add(0, 0, 1, 32'h0000_1003, 0, IF, 32'h0000_1000, 32'd4);
    // Jump to top word, then sequential wrap to 0.
    add(0, 0, 0, 0, 0, ID, 32'h0000_1000, 32'd4);
    add(0, 0, 0, 0, 0, EX, 32'h0000_1000, 32'd4);
    add(0, 0, 0, 0, 0, WB, 32'h0000_1000, 32'd4);
    add(0, 0, 1, 32'hFFFF_FFFF, 0, IF, 32'hFFFF_FFFC, 32'd5);
    add(0, 0, 0, 0, 0, ID, 32'hFFFF_FFFC, 32'd5);
    add(0, 0, 0, 0, 0, EX, 32'hFFFF_FFFC, 32'd5);
    add(0, 0, 0, 0, 0, WB, 32'hFFFF_FFFC, 32'd5);
    add(0, 0, 0, 0, 0, IF, 32'h0, 32'd6);
    // IF stall of 3 busy cycles (below the trip point of 4).
    add(1, 0, 0, 0, 0, IF, 32'h0, 32'd6);
    add(1, 0, 0, 0, 0, IF, 32'h0, 32'd6);
    add(1, 0, 0, 0, 0, IF, 32'h0, 32'd6);
    add(0, 0, 0, 0, 0, ID, 32'h0, 32'd6);
    add(0, 0, 0, 0, 0, EX, 32'h0, 32'd6);
    add(0, 0, 0, 0, 0, WB, 32'h0, 32'd6);
    add(0, 0, 0, 0, 0, IF, 32'h4, 32'd7);
    // Halt raised mid-instruction: WB completes, then HALT until dropped.
    add(0, 0, 0, 0, 1, ID, 32'h4, 32'd7);
    add(0, 0, 0, 0, 1, EX, 32'h4, 32'd7);
    add(0, 0, 0, 0, 1, WB, 32'h4, 32'd7);
    add(0, 0, 0, 0, 1, HL, 32'h8, 32'd8);
    add(1, 0, 0, 0, 1, HL, 32'h8, 32'd8);
    add(0, 0, 0, 0, 0, IF, 32'h8, 32'd8);
    // Halt that drops before WB is ignored.
    add(0, 0, 0, 0, 1, ID, 32'h8, 32'd8);
    add(0, 0, 0, 0, 0, EX, 32'h8, 32'd8);
    add(0, 0, 0, 0, 0, WB, 32'h8, 32'd8);
    add(0, 0, 0, 0, 0, IF, 32'hC, 32'd9);

    foreach (vq[i]) begin
      drive(vq[i].b, vq[i].m, vq[i].j, vq[i].ja, vq[i].h, 1'b0);
      check_all($sformatf("vec%0d", i), vq[i].es, vq[i].epc, vq[i].er, 1'b0);
    end

    // Watchdog: 4th consecutive busy cycle in IF trips into HALT.
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check_all("wd_pre", IF, 32'hC, 32'd9, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    check_all("wd_trip", HL, 32'hC, 32'd9, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check_all("wd_stuck", HL, 32'hC, 32'd9, 1'b1);
    drive(0, 0, 0, 0, 0, 1);
    check_all("wd_rreq", IF, 32'h0, 32'd9, 1'b0);

    // Reset request coinciding with a jumping WB.
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check_all("rr_wb_pre", WB, 32'h0, 32'd9, 1'b0);
    drive(0, 0, 1, 32'h0000_2000, 0, 1);
    check_all("rr_wb", IF, 32'h0, 32'd9, 1'b0);

    // Reset request during a stalled MEM access.
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check_all("rr_mem_pre", ME, 32'h0, 32'd9, 1'b0);
    drive(1, 0, 0, 0, 0, 1);
    check_all("rr_mem", IF, 32'h0, 32'd9, 1'b0);

    // Full reset clears the retired counter.
    rstn = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    check_all("rstn_mid", IF, 32'h0, 32'd0, 1'b0);
    rstn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
